// File: rtl/edge_window_sequencer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// edge_window_sequencer
//
// Purpose:
//   Streaming front-end for a pair of Sobel edge detectors. Pixels arrive one
//   per valid cycle in raster order. Two line buffers and a 3x3 shift window
//   build the neighbourhood grid. The grid goes to both detectors together with
//   the edge threshold. The two registered detector results are merged into a
//   single edge stream tagged with the centre-pixel coordinates.
//
// Configuration macro:
//   THRESH_SHADOW_EN  defined   : oThreshold is loaded from iThreshold only on
//                                 an accepted iSOF pixel, so it is fixed for a
//                                 whole frame.
//                     undefined : oThreshold follows iThreshold with one cycle
//                                 of lag.
//
// Ports:
//   clock       in   1   system clock, all state on posedge
//   iReset      in   1   asynchronous reset, active-high
//   iPixel      in   10  intensity of current pixel
//   iValid      in   1   iPixel valid this cycle (no backpressure)
//   iSOF        in   1   start of frame, qualified by iValid
//   iThreshold  in   10  requested edge threshold
//   oGrid       out  90  3x3 grid, [89:80]=top-left ... [9:0]=bottom-right
//   oGridValid  out  1   oGrid holds a new interior window (1-cycle pulse)
//   oThreshold  out  10  threshold to both detectors
//   iEdgeH      in   1   horizontal detector result (1-cycle latency)
//   iEdgeV      in   1   vertical detector result (1-cycle latency)
//   oEdge       out  1   merged edge flag for the tagged centre pixel
//   oEdgeValid  out  1   oEdge/oEdgeX/oEdgeY valid
//   oEdgeX      out  10  centre column
//   oEdgeY      out  9   centre row
//   oFrameDone  out  1   1-cycle pulse after the last pixel of a frame
// ---------------------------------------------------------------------------
module edge_window_sequencer #(
  parameter int          LINE_W     = 640,
  parameter int          FRAME_H    = 480,
  parameter logic [9:0]  THRESH_RST = 10'd100
) (
  input  logic        clock,
  input  logic        iReset,
  input  logic [9:0]  iPixel,
  input  logic        iValid,
  input  logic        iSOF,
  input  logic [9:0]  iThreshold,
  output logic [89:0] oGrid,
  output logic        oGridValid,
  output logic [9:0]  oThreshold,
  input  logic        iEdgeH,
  input  logic        iEdgeV,
  output logic        oEdge,
  output logic        oEdgeValid,
  output logic [9:0]  oEdgeX,
  output logic [8:0]  oEdgeY,
  output logic        oFrameDone
);

  localparam int COL_W = $clog2(LINE_W);
  localparam int ROW_W = $clog2(FRAME_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FRAME_H - 1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

  // Position counters
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;

  // Line buffers: lb1 holds the previous line, lb2 the line before that
  logic [9:0] r_lb1_mem [0:LINE_W-1];
  logic [9:0] r_lb2_mem [0:LINE_W-1];
  logic [9:0] r_lb1_q;
  logic [9:0] r_lb2_q;

  // 3x3 window, element p = row*3 + col (row 0 = top, col 0 = left/oldest)
  logic [8:0][9:0] r_win;
  logic [89:0]     r_grid;
  logic            r_grid_valid;

  // Tag pipe and output stage
  logic [COL_W-1:0] r_tag1_x;
  logic [ROW_W-1:0] r_tag1_y;
  logic [COL_W-1:0] r_tag2_x;
  logic [ROW_W-1:0] r_tag2_y;
  logic             r_gv_d1;
  logic             r_edge;
  logic             r_edge_valid;
  logic [9:0]       r_edge_x;
  logic [8:0]       r_edge_y;
  logic             r_frame_done;
  logic [9:0]       r_thr;

  // Combinational control
  logic             w_accept;
  logic [COL_W-1:0] w_col_eff;
  logic [ROW_W-1:0] w_row_eff;
  logic             w_col_wrap;
  logic             w_row_last;
  logic [COL_W-1:0] w_col_next;
  logic [ROW_W-1:0] w_row_next;
  logic [COL_W-1:0] w_rd_addr;
  logic             w_issue;
  logic             w_frame_end;
  logic [9:0]       w_col_in [0:2];
  logic [8:0][9:0]  w_win_next;
  logic [89:0]      w_grid_pack;

  assign w_accept    = iValid;
  // An accepted iSOF pixel is always (0,0), even in mid-frame
  assign w_col_eff   = iSOF ? '0 : r_col;
  assign w_row_eff   = iSOF ? '0 : r_row;
  assign w_col_wrap  = (w_col_eff == COL_LAST);
  assign w_row_last  = (w_row_eff == ROW_LAST);
  assign w_col_next  = w_col_wrap ? '0 : w_col_eff + COL_W'(1);
  assign w_row_next  = w_col_wrap ? (w_row_last ? '0 : w_row_eff + ROW_W'(1)) : w_row_eff;
  assign w_issue     = w_accept && (w_row_eff >= ROW_TWO) && (w_col_eff >= COL_TWO);
  assign w_frame_end = w_accept && w_col_wrap && w_row_last;

  // The RAM read is registered, so the taps for the next pixel are fetched
  // one accept ahead: the read address is the column the next accepted pixel
  // will use. The write (column c) and the prefetch (column c+1 or 0 on wrap)
  // never collide because LINE_W >= 3. A mid-frame iSOF lands on column 0
  // with taps fetched for the old column; that pixel is on row 0, whose taps
  // never reach a valid window, so the mismatch is harmless.
  assign w_rd_addr = w_accept ? w_col_next : r_col;

  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_lb1_mem[w_col_eff] <= iPixel;
      r_lb2_mem[w_col_eff] <= r_lb1_q;
    end
    r_lb1_q <= r_lb1_mem[w_rd_addr];
    r_lb2_q <= r_lb2_mem[w_rd_addr];
  end

  // Incoming right-hand column: top from lb2, middle from lb1, bottom live
  assign w_col_in[0] = r_lb2_q;
  assign w_col_in[1] = r_lb1_q;
  assign w_col_in[2] = iPixel;

  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_win
      if ((gi % 3) == 2) begin : g_new
        assign w_win_next[gi] = w_col_in[gi / 3];
      end else begin : g_shift
        assign w_win_next[gi] = r_win[gi + 1];
      end
      // Top-left (p=0) occupies the most significant slot of the grid bus
      assign w_grid_pack[10*(8-gi) +: 10] = w_win_next[gi];
    end
  endgenerate

  always_ff @(posedge clock or posedge iReset) begin
    if (iReset) begin
      r_col        <= '0;
      r_row        <= '0;
      r_win        <= '0;
      r_grid       <= '0;
      r_grid_valid <= 1'b0;
      r_tag1_x     <= '0;
      r_tag1_y     <= '0;
      r_tag2_x     <= '0;
      r_tag2_y     <= '0;
      r_gv_d1      <= 1'b0;
      r_edge       <= 1'b0;
      r_edge_valid <= 1'b0;
      r_edge_x     <= '0;
      r_edge_y     <= '0;
      r_frame_done <= 1'b0;
      r_thr        <= THRESH_RST;
    end else begin
      r_grid_valid <= w_issue;
      r_gv_d1      <= r_grid_valid;
      r_edge_valid <= r_gv_d1;
      // Detectors answer one cycle after oGridValid; outside that slot the
      // edge output is forced low so it never reflects a stale window.
      r_edge       <= r_gv_d1 & (iEdgeH | iEdgeV);
      r_frame_done <= w_frame_end;

      if (w_accept) begin
        r_col <= w_col_next;
        r_row <= w_row_next;
        r_win <= w_win_next;
      end

      if (w_issue) begin
        r_grid   <= w_grid_pack;
        r_tag1_x <= w_col_eff - COL_W'(1);
        r_tag1_y <= w_row_eff - ROW_W'(1);
      end

      if (r_grid_valid) begin
        r_tag2_x <= r_tag1_x;
        r_tag2_y <= r_tag1_y;
      end

      if (r_gv_d1) begin
        r_edge_x <= 10'(r_tag2_x);
        r_edge_y <= 9'(r_tag2_y);
      end

`ifdef THRESH_SHADOW_EN
      if (w_accept && iSOF) begin
        r_thr <= iThreshold;
      end
`else
      r_thr <= iThreshold;
`endif
    end
  end

  assign oGrid      = r_grid;
  assign oGridValid = r_grid_valid;
  assign oThreshold = r_thr;
  assign oEdge      = r_edge;
  assign oEdgeValid = r_edge_valid;
  assign oEdgeX     = r_edge_x;
  assign oEdgeY     = r_edge_y;
  assign oFrameDone = r_frame_done;

endmodule

// File: tb/tb_edge_window_sequencer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_edge_window_sequencer
//
// Scoreboard bench for edge_window_sequencer with LINE_W=8, FRAME_H=6.
// Sobel H/V detectors are modelled as registered blocks fed from oGrid and
// oThreshold. Expected (X,Y,edge) results are computed from a stored image
// when each pixel is driven and popped when oEdgeValid fires.
// ---------------------------------------------------------------------------
module tb_edge_window_sequencer;

  localparam int LW = 8;
  localparam int FH = 6;

  typedef struct {
    int x;
    int y;
    bit e;
  } exp_t;

  logic        clock = 1'b0;
  logic        clk_en = 1'b1;
  logic        iReset = 1'b1;
  logic [9:0]  iPixel = '0;
  logic        iValid = 1'b0;
  logic        iSOF = 1'b0;
  logic [9:0]  iThreshold = 10'd100;
  logic [89:0] oGrid;
  logic        oGridValid;
  logic [9:0]  oThreshold;
  logic        iEdgeH = 1'b0;
  logic        iEdgeV = 1'b0;
  logic        oEdge;
  logic        oEdgeValid;
  logic [9:0]  oEdgeX;
  logic [8:0]  oEdgeY;
  logic        oFrameDone;

  always #5 if (clk_en) clock = ~clock;

  edge_window_sequencer #(
    .LINE_W    (LW),
    .FRAME_H   (FH),
    .THRESH_RST(10'd100)
  ) dut (
    .clock     (clock),
    .iReset    (iReset),
    .iPixel    (iPixel),
    .iValid    (iValid),
    .iSOF      (iSOF),
    .iThreshold(iThreshold),
    .oGrid     (oGrid),
    .oGridValid(oGridValid),
    .oThreshold(oThreshold),
    .iEdgeH    (iEdgeH),
    .iEdgeV    (iEdgeV),
    .oEdge     (oEdge),
    .oEdgeValid(oEdgeValid),
    .oEdgeX    (oEdgeX),
    .oEdgeY    (oEdgeY),
    .oFrameDone(oFrameDone)
  );

  // ---------------- detector models (registered, 1-cycle latency) ---------
  function automatic int abs_i(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int gp(input logic [89:0] g, input int p);
    return int'(g[10*(8-p) +: 10]);
  endfunction

  function automatic bit det_h(input logic [89:0] g, input int thr);
    int gy;
    gy = (gp(g,6) + 2*gp(g,7) + gp(g,8)) - (gp(g,0) + 2*gp(g,1) + gp(g,2));
    return abs_i(gy) > thr;
  endfunction

  function automatic bit det_v(input logic [89:0] g, input int thr);
    int gx;
    gx = (gp(g,2) + 2*gp(g,5) + gp(g,8)) - (gp(g,0) + 2*gp(g,3) + gp(g,6));
    return abs_i(gx) > thr;
  endfunction

  always @(posedge clock) begin
    iEdgeH <= det_h(oGrid, int'(oThreshold));
    iEdgeV <= det_v(oGrid, int'(oThreshold));
  end

  // ---------------- bench state ----------------
  int   img [0:FH-1][0:LW-1];
  exp_t q[$];
  int   b_col = 0, b_row = 0;
  int   thr_frame = 100;
  bit   exp_gv = 1'b0;
  bit   exp_done = 1'b0;
  logic [89:0] exp_grid = '0;
  int   n_gv = 0, n_out = 0, n_edges = 0, n_done = 0;
  int   n_checks = 0, n_pass = 0;

  task automatic check_val(input string tag, input logic [89:0] obs, input logic [89:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Image-based reference: Sobel at centre (x,y), either gradient over thr
  function automatic bit model_edge(input int x, input int y, input int thr);
    int gx, gy;
    gx = (img[y-1][x+1] + 2*img[y][x+1] + img[y+1][x+1])
       - (img[y-1][x-1] + 2*img[y][x-1] + img[y+1][x-1]);
    gy = (img[y+1][x-1] + 2*img[y+1][x] + img[y+1][x+1])
       - (img[y-1][x-1] + 2*img[y-1][x] + img[y-1][x+1]);
    return (abs_i(gx) > thr) || (abs_i(gy) > thr);
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      iValid = 1'b0;
      iSOF = 1'b0;
      exp_gv = 1'b0;
      exp_done = 1'b0;
    end
  endtask

  task automatic send_px(input int pix, input bit sof, input int thr, input bit gap);
    exp_t e;
    int use_thr;
    if (gap) idle(1);
    @(negedge clock);
    if (sof) begin
      b_col = 0;
      b_row = 0;
      thr_frame = thr;
    end
    iValid = 1'b1;
    iPixel = 10'(pix);
    iSOF = sof;
    iThreshold = 10'(thr);
    img[b_row][b_col] = pix;
    exp_gv = (b_row >= 2) && (b_col >= 2);
    if (exp_gv) begin
      for (int p = 0; p < 9; p++)
        exp_grid[10*(8-p) +: 10] = 10'(img[b_row-2+p/3][b_col-2+p%3]);
`ifdef THRESH_SHADOW_EN
      use_thr = thr_frame;
`else
      use_thr = thr;
`endif
      e.x = b_col - 1;
      e.y = b_row - 1;
      e.e = model_edge(b_col - 1, b_row - 1, use_thr);
      q.push_back(e);
    end
    exp_done = (b_col == LW-1) && (b_row == FH-1);
    if (b_col == LW-1) begin
      b_col = 0;
      b_row = (b_row == FH-1) ? 0 : b_row + 1;
    end else begin
      b_col = b_col + 1;
    end
  endtask

  function automatic int step_px(input int col);
    return (col < 4) ? 0 : 200;
  endfunction

  task automatic drain();
    int k;
    k = 0;
    while (q.size() != 0 && k < 50) begin
      idle(1);
      k++;
    end
    idle(4);
    check_val("drain_queue_empty", q.size(), 0);
  endtask

  // ---------------- output monitor ----------------
  always begin
    exp_t e;
    @(posedge clock);
    #1;
    if (oGridValid || exp_gv) begin
      check_val("grid_valid", oGridValid, exp_gv);
      if (oGridValid && exp_gv) check_val("grid", oGrid, exp_grid);
    end
    if (oGridValid) n_gv++;
    if (oFrameDone || exp_done) check_val("frame_done", oFrameDone, exp_done);
    if (oFrameDone) n_done++;
    if (oEdgeValid) begin
      n_out++;
      if (oEdge) n_edges++;
      if (q.size() == 0) begin
        check_val("queue_depth_at_output", q.size(), 1);
      end else begin
        e = q.pop_front();
        $display("out X=%0d Y=%0d edge=%0d (exp X=%0d Y=%0d edge=%0d)",
                 oEdgeX, oEdgeY, oEdge, e.x, e.y, e.e);
        check_val("edge_x", oEdgeX, e.x);
        check_val("edge_y", oEdgeY, e.y);
        check_val("edge", oEdge, e.e);
      end
    end else if (oEdge) begin
      check_val("edge_without_valid", oEdge, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  int o0, e0, d0, g0;

  initial begin
    // Power-on reset
    iReset = 1'b1;
    repeat (3) @(negedge clock);
    check_val("rst_threshold", oThreshold, 100);
    check_val("rst_grid_valid", oGridValid, 0);
    check_val("rst_edge_valid", oEdgeValid, 0);
    check_val("rst_frame_done", oFrameDone, 0);
    iReset = 1'b0;
    iThreshold = 10'd250;
    idle(2);
`ifdef THRESH_SHADOW_EN
    check_val("thr_idle_hold", oThreshold, 100);
`else
    check_val("thr_follow", oThreshold, 250);
`endif

    // Test 1: reset mid-frame with the clock stopped
    for (int i = 0; i < 30; i++) send_px(step_px(i % LW), i == 0, 300, 1'b0);
    @(negedge clock);
    iValid = 1'b0;
    iSOF = 1'b0;
    clk_en = 1'b0;
    #2;
    iReset = 1'b1;
    #1;
    check_val("async_rst_grid", oGrid, 0);
    check_val("async_rst_grid_valid", oGridValid, 0);
    check_val("async_rst_edge", oEdge, 0);
    check_val("async_rst_edge_valid", oEdgeValid, 0);
    check_val("async_rst_edge_x", oEdgeX, 0);
    check_val("async_rst_edge_y", oEdgeY, 0);
    check_val("async_rst_frame_done", oFrameDone, 0);
    check_val("async_rst_threshold", oThreshold, 100);
    q.delete();
    exp_gv = 1'b0;
    exp_done = 1'b0;
    b_col = 0;
    b_row = 0;
    thr_frame = 100;
    iThreshold = 10'd100;
    #3;
    clk_en = 1'b1;
    repeat (2) @(negedge clock);
    iReset = 1'b0;
    idle(2);

    // Test 2: flat frame
    o0 = n_out; e0 = n_edges; d0 = n_done; g0 = n_gv;
    for (int i = 0; i < LW*FH; i++) send_px(100, i == 0, 100, 1'b0);
    drain();
    check_val("flat_outputs", n_out - o0, 24);
    check_val("flat_grids", n_gv - g0, 24);
    check_val("flat_edges", n_edges - e0, 0);
    check_val("flat_frame_done", n_done - d0, 1);

    // Test 3: vertical step
    o0 = n_out; e0 = n_edges; d0 = n_done;
    for (int i = 0; i < LW*FH; i++) send_px(step_px(i % LW), i == 0, 100, 1'b0);
    drain();
    check_val("step_outputs", n_out - o0, 24);
    check_val("step_edges", n_edges - e0, 8);
    check_val("step_frame_done", n_done - d0, 1);

    // Test 4: same step with iValid gaps
    o0 = n_out; e0 = n_edges; d0 = n_done;
    for (int i = 0; i < LW*FH; i++) send_px(step_px(i % LW), i == 0, 100, 1'b1);
    drain();
    check_val("gap_outputs", n_out - o0, 24);
    check_val("gap_edges", n_edges - e0, 8);
    check_val("gap_frame_done", n_done - d0, 1);

    // Test 5: threshold 100 -> 900 from row 3, then a full 900 frame
    o0 = n_out; e0 = n_edges; d0 = n_done;
    for (int i = 0; i < LW*FH; i++)
      send_px(step_px(i % LW), i == 0, ((i / LW) >= 3) ? 900 : 100, 1'b0);
    for (int i = 0; i < LW*FH; i++) send_px(step_px(i % LW), i == 0, 900, 1'b0);
    drain();
    check_val("thr_outputs", n_out - o0, 48);
`ifdef THRESH_SHADOW_EN
    check_val("thr_edges", n_edges - e0, 8);
`else
    check_val("thr_edges", n_edges - e0, 2);
`endif
    check_val("thr_frame_done", n_done - d0, 2);

    // Test 6: mid-frame iSOF at (5,3)
    o0 = n_out; e0 = n_edges; d0 = n_done; g0 = n_gv;
    for (int i = 0; i < 3*LW + 5; i++) send_px(step_px(i % LW), i == 0, 100, 1'b0);
    for (int i = 0; i < LW*FH; i++) send_px(step_px(i % LW), i == 0, 100, 1'b0);
    drain();
    check_val("sof_outputs", n_out - o0, 33);
    check_val("sof_grids", n_gv - g0, 33);
    check_val("sof_edges", n_edges - e0, 11);
    check_val("sof_frame_done", n_done - d0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
